// File: rtl/mips_ctrl_alu.sv
// -----------------------------------------------------------------------------
// mips_ctrl_alu
//
// Control-and-execute block for the 5-stage pipelined MIPS-subset core.
//   * Main decoder (ID stage): Opcode -> registered datapath control bits.
//   * ALU-control decoder: ALUOpIn + Funct -> 5-bit ALU operation code (comb).
//   * ALU (EX stage): A op B -> Result, plus Zero flag (comb).
// The decoder and the EX logic take separate inputs; the ID/EX pipeline
// register lives outside this block.
//
// Ports
//   Clk, Rst_n      rising-edge clock, asynchronous active-low reset
//   Opcode  [5:0]   instr[31:26] from IF/ID
//   Funct   [5:0]   instr[5:0] from ID/EX
//   ALUOpIn [1:0]   ALUOp carried in ID/EX
//   A, B            ALU operands (B already muxed with the immediate)
//   ALUOp .. RegDst registered control outputs, cleared by reset
//   Op      [4:0]   ALU operation code
//   Result          ALU result
//   Zero            Result == 0
// -----------------------------------------------------------------------------
module mips_ctrl_alu #(
   parameter int DATA_W = 32
) (
   input  logic              Clk,
   input  logic              Rst_n,
   input  logic [5:0]        Opcode,
   input  logic [5:0]        Funct,
   input  logic [1:0]        ALUOpIn,
   input  logic [DATA_W-1:0] A,
   input  logic [DATA_W-1:0] B,
   output logic [1:0]        ALUOp,
   output logic              RegWrite,
   output logic              MemtoReg,
   output logic              MemRead,
   output logic              MemWrite,
   output logic              Branch,
   output logic              ALUSrc,
   output logic              RegDst,
   output logic [4:0]        Op,
   output logic [DATA_W-1:0] Result,
   output logic              Zero
);

   typedef enum logic [4:0] {
      OP_AND  = 5'b00000,
      OP_OR   = 5'b00001,
      OP_ADD  = 5'b00010,
      OP_XOR  = 5'b00011,
      OP_SUB  = 5'b00110,
      OP_SLT  = 5'b00111,
      OP_SLTU = 5'b01000,
      OP_NOR  = 5'b01100
   } alu_op_e;

   typedef struct packed {
      logic [1:0] alu_op;
      logic       reg_write;
      logic       mem_to_reg;
      logic       mem_read;
      logic       mem_write;
      logic       branch;
      logic       alu_src;
      logic       reg_dst;
   } ctrl_t;

   localparam logic [5:0] OPC_RTYPE = 6'b000000;
   localparam logic [5:0] OPC_LW    = 6'b100011;
   localparam logic [5:0] OPC_SW    = 6'b101011;
   localparam logic [5:0] OPC_BEQ   = 6'b000100;
   localparam logic [5:0] OPC_ADDI  = 6'b001000;

   ctrl_t ctrl_d, ctrl_q;

   // ---------------------------------------------------------------------------
   // Main decoder
   // ---------------------------------------------------------------------------
   always_comb begin
      // NOTE: default every field first so no path through the case leaves a
      // bit unassigned (that would infer a latch); unknown opcodes become nops.
      ctrl_d = '0;
      unique case (Opcode)
         OPC_RTYPE: begin
            ctrl_d.reg_dst   = 1'b1;
            ctrl_d.reg_write = 1'b1;
            ctrl_d.alu_op    = 2'b10;
         end
         OPC_LW: begin
            ctrl_d.alu_src    = 1'b1;
            ctrl_d.mem_to_reg = 1'b1;
            ctrl_d.reg_write  = 1'b1;
            ctrl_d.mem_read   = 1'b1;
         end
         OPC_SW: begin
            ctrl_d.alu_src   = 1'b1;
            ctrl_d.mem_write = 1'b1;
         end
         OPC_BEQ: begin
            ctrl_d.branch = 1'b1;
            ctrl_d.alu_op = 2'b01;
         end
         OPC_ADDI: begin
            ctrl_d.alu_src   = 1'b1;
            ctrl_d.reg_write = 1'b1;
         end
         default: ctrl_d = '0;
      endcase
   end

   always_ff @(posedge Clk or negedge Rst_n) begin
      // NOTE: non-blocking assignment for state so every flop samples the
      // pre-edge value regardless of block evaluation order.
      if (!Rst_n) ctrl_q <= '0;
      else        ctrl_q <= ctrl_d;
   end

   assign ALUOp    = ctrl_q.alu_op;
   assign RegWrite = ctrl_q.reg_write;
   assign MemtoReg = ctrl_q.mem_to_reg;
   assign MemRead  = ctrl_q.mem_read;
   assign MemWrite = ctrl_q.mem_write;
   assign Branch   = ctrl_q.branch;
   assign ALUSrc   = ctrl_q.alu_src;
   assign RegDst   = ctrl_q.reg_dst;

   // ---------------------------------------------------------------------------
   // ALU-control decoder: ALUOp 00/11 -> add (address calc / addi),
   // 01 -> sub (beq compare), 10 -> R-type funct field.
   // ---------------------------------------------------------------------------
   alu_op_e op;

   always_comb begin
      op = OP_ADD;
      if (ALUOpIn == 2'b01) begin
         op = OP_SUB;
      end else if (ALUOpIn == 2'b10) begin
         unique case (Funct)
            6'b100000: op = OP_ADD;
            6'b100010: op = OP_SUB;
            6'b100100: op = OP_AND;
            6'b100101: op = OP_OR;
            6'b100110: op = OP_XOR;
            6'b100111: op = OP_NOR;
            6'b101010: op = OP_SLT;
            6'b101011: op = OP_SLTU;
            default:   op = OP_ADD;
         endcase
      end
   end

   assign Op = op;

   // ---------------------------------------------------------------------------
   // ALU
   // ---------------------------------------------------------------------------
   logic slt_s, slt_u;

   assign slt_s = $signed(A) < $signed(B);
   assign slt_u = A < B;

   always_comb begin
      Result = '0;
      case (Op)
         OP_AND:  Result = A & B;
         OP_OR:   Result = A | B;
         OP_ADD:  Result = A + B;
         OP_XOR:  Result = A ^ B;
         OP_SUB:  Result = A - B;
         OP_SLT:  Result = {{(DATA_W-1){1'b0}}, slt_s};
         OP_SLTU: Result = {{(DATA_W-1){1'b0}}, slt_u};
         OP_NOR:  Result = ~(A | B);
         default: Result = '0;
      endcase
   end

   assign Zero = (Result == '0);

endmodule

// File: tb/tb_mips_ctrl_alu.sv
// -----------------------------------------------------------------------------
// tb_mips_ctrl_alu
//
// Directed-vector bench for mips_ctrl_alu. Stimulus pushes hand-computed
// expectations (tagged with the cycle they become due) into two queues; a
// monitor on the falling edge pops and compares whatever is due.
// -----------------------------------------------------------------------------
module tb_mips_ctrl_alu;

   localparam int DATA_W = 32;

   // Control vector layout: {ALUOp[1:0], RegWrite, MemtoReg, MemRead,
   //                         MemWrite, Branch, ALUSrc, RegDst}
   localparam logic [8:0] C_NOP  = 9'b00_0000000;
   localparam logic [8:0] C_R    = 9'b10_1000001;
   localparam logic [8:0] C_LW   = 9'b00_1110010;
   localparam logic [8:0] C_SW   = 9'b00_0001010;
   localparam logic [8:0] C_BEQ  = 9'b01_0000100;
   localparam logic [8:0] C_ADDI = 9'b00_1000010;

   logic              Clk;
   logic              Rst_n;
   logic [5:0]        Opcode;
   logic [5:0]        Funct;
   logic [1:0]        ALUOpIn;
   logic [DATA_W-1:0] A;
   logic [DATA_W-1:0] B;
   logic [1:0]        ALUOp;
   logic              RegWrite;
   logic              MemtoReg;
   logic              MemRead;
   logic              MemWrite;
   logic              Branch;
   logic              ALUSrc;
   logic              RegDst;
   logic [4:0]        Op;
   logic [DATA_W-1:0] Result;
   logic              Zero;

   mips_ctrl_alu #(.DATA_W(DATA_W)) dut (
      .Clk      (Clk),
      .Rst_n    (Rst_n),
      .Opcode   (Opcode),
      .Funct    (Funct),
      .ALUOpIn  (ALUOpIn),
      .A        (A),
      .B        (B),
      .ALUOp    (ALUOp),
      .RegWrite (RegWrite),
      .MemtoReg (MemtoReg),
      .MemRead  (MemRead),
      .MemWrite (MemWrite),
      .Branch   (Branch),
      .ALUSrc   (ALUSrc),
      .RegDst   (RegDst),
      .Op       (Op),
      .Result   (Result),
      .Zero     (Zero)
   );

   initial begin
      Clk = 1'b0;
      forever #5 Clk = ~Clk;
   end

   int cyc = 0;
   always @(posedge Clk) cyc <= cyc + 1;

   typedef struct {
      string      name;
      int         due;
      logic [8:0] ctrl;
   } ctrl_exp_t;

   typedef struct {
      string             name;
      int                due;
      logic [4:0]        op;
      logic [DATA_W-1:0] res;
      logic              zero;
   } alu_exp_t;

   ctrl_exp_t ctrl_sb[$];
   alu_exp_t  alu_sb[$];

   int n_checks = 0;
   int n_fail   = 0;

   // --------------------------------------------------------------------------
   // Monitor
   // --------------------------------------------------------------------------
   ctrl_exp_t ce;
   alu_exp_t  ae;
   logic [8:0] ctrl_act;

   always @(negedge Clk) begin
      while (ctrl_sb.size() > 0 && ctrl_sb[0].due <= cyc) begin
         ce = ctrl_sb.pop_front();
         ctrl_act = {ALUOp, RegWrite, MemtoReg, MemRead, MemWrite, Branch, ALUSrc, RegDst};
         n_checks++;
         if (ctrl_act !== ce.ctrl || ce.due != cyc) begin
            n_fail++;
            $display("FAIL %s: ctrl got %b want %b (cycle %0d, due %0d)",
                     ce.name, ctrl_act, ce.ctrl, cyc, ce.due);
         end
      end
      while (alu_sb.size() > 0 && alu_sb[0].due <= cyc) begin
         ae = alu_sb.pop_front();
         n_checks++;
         if (Op !== ae.op || Result !== ae.res || Zero !== ae.zero || ae.due != cyc) begin
            n_fail++;
            $display("FAIL %s: got op=%b res=%h zero=%b want op=%b res=%h zero=%b",
                     ae.name, Op, Result, Zero, ae.op, ae.res, ae.zero);
         end
      end
   end

   // --------------------------------------------------------------------------
   // Stimulus helpers
   // --------------------------------------------------------------------------
   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   task automatic exp_ctrl(input string n, input int lat, input logic [8:0] v);
      ctrl_exp_t e;
      e.name = n;
      e.due  = cyc + lat;
      e.ctrl = v;
      ctrl_sb.push_back(e);
   endtask

   task automatic drive_op(input string n, input logic [5:0] opc, input logic [8:0] v);
      Opcode = opc;
      exp_ctrl(n, 1, v);
      step();
   endtask

   task automatic alu_vec(input string n, input logic [1:0] aop, input logic [5:0] f,
                          input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                          input logic [4:0] eop, input logic [DATA_W-1:0] eres,
                          input logic ez);
      alu_exp_t e;
      ALUOpIn = aop;
      Funct   = f;
      A       = a;
      B       = b;
      e.name  = n;
      e.due   = cyc;
      e.op    = eop;
      e.res   = eres;
      e.zero  = ez;
      alu_sb.push_back(e);
      step();
   endtask

   // --------------------------------------------------------------------------
   // Stimulus
   // --------------------------------------------------------------------------
   initial begin
      Rst_n   = 1'b0;
      Opcode  = 6'b100011;
      Funct   = 6'b000000;
      ALUOpIn = 2'b00;
      A       = '0;
      B       = '0;
      step();
      step();

      // Reset holds control at zero even with lw on the opcode bus
      exp_ctrl("reset_clear", 0, C_NOP);
      step();
      Rst_n = 1'b1;
      exp_ctrl("reset_still_zero", 0, C_NOP);
      exp_ctrl("lw_after_release", 1, C_LW);
      step();

      // Decode sequence, 1-cycle latency
      drive_op("rtype", 6'b000000, C_R);
      drive_op("sw",    6'b101011, C_SW);
      drive_op("nop_3f", 6'b111111, C_NOP);
      drive_op("beq",   6'b000100, C_BEQ);
      drive_op("addi",  6'b001000, C_ADDI);
      exp_ctrl("addi_hold", 0, C_ADDI);
      step();

      // Mid-cycle async reset clears immediately; ALU keeps tracking
      Rst_n = 1'b0;
      exp_ctrl("midcycle_reset", 0, C_NOP);
      alu_vec("alu_during_reset", 2'b01, 6'b000000, 32'd9, 32'd4, 5'b00110, 32'd5, 1'b0);
      Rst_n = 1'b1;
      exp_ctrl("addi_after_reset", 1, C_ADDI);
      step();

      // ALU vectors
      alu_vec("add_wrap",   2'b10, 6'b100000, 32'hFFFF_FFFF, 32'd1, 5'b00010, 32'h0000_0000, 1'b1);
      alu_vec("sub_neg",    2'b10, 6'b100010, 32'd5, 32'd7,         5'b00110, 32'hFFFF_FFFE, 1'b0);
      alu_vec("beq_equal",  2'b01, 6'b101010, 32'h1234, 32'h1234,   5'b00110, 32'h0000_0000, 1'b1);
      alu_vec("beq_neq",    2'b01, 6'b101010, 32'h1234, 32'h1235,   5'b00110, 32'hFFFF_FFFF, 1'b0);
      alu_vec("slt_neg",    2'b10, 6'b101010, 32'hFFFF_FFFF, 32'd1, 5'b00111, 32'd1, 1'b0);
      alu_vec("sltu_big",   2'b10, 6'b101011, 32'hFFFF_FFFF, 32'd1, 5'b01000, 32'd0, 1'b1);
      alu_vec("slt_pos",    2'b10, 6'b101010, 32'd3, 32'hFFFF_FFFF, 5'b00111, 32'd0, 1'b1);
      alu_vec("sltu_small", 2'b10, 6'b101011, 32'd3, 32'hFFFF_FFFF, 5'b01000, 32'd1, 1'b0);
      alu_vec("and",        2'b10, 6'b100100, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 5'b00000, 32'h00F0_00F0, 1'b0);
      alu_vec("or",         2'b10, 6'b100101, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 5'b00001, 32'hFFF0_FFF0, 1'b0);
      alu_vec("xor",        2'b10, 6'b100110, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 5'b00011, 32'hFF00_FF00, 1'b0);
      alu_vec("nor",        2'b10, 6'b100111, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 5'b01100, 32'h000F_000F, 1'b0);
      alu_vec("funct_dflt", 2'b10, 6'b111111, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 5'b00010, 32'h00E1_00E0, 1'b0);
      alu_vec("aluop00_add",2'b00, 6'b100010, 32'd10, 32'd20,       5'b00010, 32'd30, 1'b0);
      alu_vec("aluop11_add",2'b11, 6'b100010, 32'd1, 32'd2,         5'b00010, 32'd3, 1'b0);

      repeat (3) step();

      // Every pushed expectation must have been consumed by the monitor
      n_checks++;
      if (ctrl_sb.size() != 0 || alu_sb.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain: %0d ctrl and %0d alu left, want 0 and 0",
                  ctrl_sb.size(), alu_sb.size());
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation still running at %0t, want finished", $time);
      $fatal(1, "timeout");
   end

endmodule
